// File: rtl/conv3x3_engine_if.sv
// Window/coefficient/pixel bus of the 3x3 convolution engine.
// The master side feeds windows and kernel writes; the slave side is the engine.
interface conv3x3_engine_if;
   logic [35:0] window_in;
   logic        window_valid;
   logic        coef_we;
   logic [3:0]  coef_addr;
   logic [3:0]  coef_data;
   logic [3:0]  pix_out;
   logic        pix_valid;
   logic        last_col;
   logic        frame_done;

   modport master (
      output window_in, window_valid, coef_we, coef_addr, coef_data,
      input  pix_out, pix_valid, last_col, frame_done
   );

   modport slave (
      input  window_in, window_valid, coef_we, coef_addr, coef_data,
      output pix_out, pix_valid, last_col, frame_done
   );
endinterface

// File: rtl/conv3x3_engine.sv
// 3-stage pipelined 3x3 convolution with loadable signed kernel, shift/saturate
// normaliser and output position tracking. Define CONV_ABS_EN for |sum| output.
module conv3x3_engine #(
   parameter int WIDTH  = 400,
   parameter int ROWS   = 398,
   parameter int SHIFT  = 3,
   parameter int DATA_W = 4,
   parameter int COEF_W = 4
) (
   input  logic clk,
   input  logic reset,
   conv3x3_engine_if.slave bus
);
   localparam int PROD_W = 9;
   localparam int SUM_W  = 13;
   localparam int CW     = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam int RW     = (ROWS > 1) ? $clog2(ROWS) : 1;

   logic signed [COEF_W-1:0] coef [9];
   logic signed [PROD_W-1:0] prod_p1 [9];
   logic                     vld_p1;
   logic signed [SUM_W-1:0]  sum_acc;
   logic signed [SUM_W-1:0]  sum_p2;
   logic                     vld_p2;
   logic [DATA_W-1:0]        pix_p3;
   logic                     vld_p3;
   logic                     last_p3;
   logic                     done_p3;
   logic [CW-1:0]            col;
   logic [RW-1:0]            row;
   logic                     at_last_col;
   logic                     at_last_row;

   // Unsigned pixel times signed coefficient, both widened to the product width.
   function automatic logic signed [PROD_W-1:0] mul_pix(input logic [DATA_W-1:0] p,
                                                        input logic signed [COEF_W-1:0] k);
      logic signed [PROD_W-1:0] pe;
      logic signed [PROD_W-1:0] ke;
      pe = {{(PROD_W-DATA_W){1'b0}}, p};
      ke = {{(PROD_W-COEF_W){k[COEF_W-1]}}, k};
      return pe * ke;
   endfunction

   function automatic logic [DATA_W-1:0] norm_sat(input logic signed [SUM_W-1:0] sum);
      logic signed [SUM_W-1:0] s;
`ifdef CONV_ABS_EN
      s = (sum < 0) ? -sum : sum;
      s = s >>> SHIFT;
`else
      s = sum >>> SHIFT;
`endif
      if (s < 0)
         return '0;
      else if (s > 15)
         return 4'd15;
      else
         return s[DATA_W-1:0];
   endfunction

   // Kernel registers: box kernel after reset, writes to indices 9..15 dropped.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < 9; i++) coef[i] <= 4'sd1;
      end else if (bus.coef_we) begin
         for (int i = 0; i < 9; i++)
            if (bus.coef_addr == 4'(i)) coef[i] <= $signed(bus.coef_data);
      end
   end

   // Stage 1: nine products
   always_ff @(posedge clk) begin
      for (int i = 0; i < 9; i++)
         prod_p1[i] <= mul_pix(bus.window_in[35-4*i -: 4], coef[i]);
   end

   always_comb begin
      sum_acc = '0;
      for (int i = 0; i < 9; i++)
         sum_acc = sum_acc + {{(SUM_W-PROD_W){prod_p1[i][PROD_W-1]}}, prod_p1[i]};
   end

   // Stage 2: adder tree
   always_ff @(posedge clk) begin
      sum_p2 <= sum_acc;
   end

   assign at_last_col = (col == CW'(WIDTH - 1));
   assign at_last_row = (row == RW'(ROWS - 1));

   // Stage 3: normalise, saturate, tag with position taken before the counter step
   always_ff @(posedge clk) begin
      if (reset) begin
         vld_p1  <= 1'b0;
         vld_p2  <= 1'b0;
         vld_p3  <= 1'b0;
         pix_p3  <= '0;
         last_p3 <= 1'b0;
         done_p3 <= 1'b0;
         col     <= '0;
         row     <= '0;
      end else begin
         vld_p1  <= bus.window_valid;
         vld_p2  <= vld_p1;
         vld_p3  <= vld_p2;
         pix_p3  <= norm_sat(sum_p2);
         last_p3 <= vld_p2 && at_last_col;
         done_p3 <= vld_p2 && at_last_col && at_last_row;
         if (vld_p2) begin
            if (at_last_col) begin
               col <= '0;
               row <= at_last_row ? '0 : row + 1'b1;
            end else begin
               col <= col + 1'b1;
            end
         end
      end
   end

   assign bus.pix_out    = pix_p3;
   assign bus.pix_valid  = vld_p3;
   assign bus.last_col   = last_p3;
   assign bus.frame_done = done_p3;
endmodule

// File: tb/tb_conv3x3_engine.sv
// Scoreboard bench for conv3x3_engine with a 4x2 output frame and SHIFT=3.
module tb_conv3x3_engine;
   localparam int W  = 4;
   localparam int R  = 2;
   localparam int SH = 3;

   typedef struct {
      int pix;
      bit last;
      bit fd;
      int due;
   } exp_t;

   logic clk = 1'b0;
   logic reset;
   int   cyc = 0;
   int   total = 0;
   int   bad = 0;
   int   oi = 0;
   exp_t sb[$];

   conv3x3_engine_if bus();

   conv3x3_engine #(.WIDTH(W), .ROWS(R), .SHIFT(SH)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input int act, input int req);
      total++;
      if (act != req) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Monitor: every emitted pixel must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (!reset) begin
         if (bus.pix_valid) begin
            if (sb.size() == 0) begin
               chk("unexpected_pix_valid", 1, 0);
            end else begin
               exp_t e;
               e = sb.pop_front();
               chk("pix_out", int'(bus.pix_out), e.pix);
               chk("last_col", int'(bus.last_col), int'(e.last));
               chk("frame_done", int'(bus.frame_done), int'(e.fd));
               chk("latency", cyc, e.due);
            end
         end else begin
            if (bus.last_col || bus.frame_done)
               chk("flag_without_valid", 1, 0);
         end
      end
   end

   function automatic logic [35:0] flat(input int v);
      logic [35:0] w;
      for (int i = 0; i < 9; i++) w[35-4*i -: 4] = 4'(v);
      return w;
   endfunction

   // One cycle of stimulus, driven at the falling edge; optional window and coef write.
   task automatic step(input bit wv, input logic [35:0] w, input int exp_pix,
                       input bit we, input int addr, input int data);
      bus.window_in    = w;
      bus.window_valid = wv;
      bus.coef_we      = we;
      bus.coef_addr    = 4'(addr);
      bus.coef_data    = 4'(data);
      if (wv) begin
         exp_t e;
         e.pix  = exp_pix;
         e.last = ((oi % W) == W - 1);
         e.fd   = e.last && (((oi / W) % R) == R - 1);
         e.due  = cyc + 3;
         oi++;
         sb.push_back(e);
      end
      @(negedge clk);
      bus.window_valid = 1'b0;
      bus.coef_we      = 1'b0;
   endtask

   task automatic win(input logic [35:0] w, input int exp_pix);
      step(1'b1, w, exp_pix, 1'b0, 0, 0);
   endtask

   task automatic wr(input int addr, input int data);
      step(1'b0, '0, 0, 1'b1, addr, data);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, '0, 0, 1'b0, 0, 0);
   endtask

   task automatic drain();
      int guard;
      guard = 0;
      while (sb.size() != 0 && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      chk("drain_outstanding", sb.size(), 0);
   endtask

   task automatic check_idle_outputs(input string tag);
      chk({tag, "_pix_out"}, int'(bus.pix_out), 0);
      chk({tag, "_pix_valid"}, int'(bus.pix_valid), 0);
      chk({tag, "_last_col"}, int'(bus.last_col), 0);
      chk({tag, "_frame_done"}, int'(bus.frame_done), 0);
   endtask

   // 0..15 box-kernel table: flat window v gives (9*v)>>3.
   int vals[8] = '{0, 1, 2, 3, 4, 7, 10, 13};
   int outs[8] = '{0, 1, 2, 3, 4, 7, 11, 14};

   initial begin
      logic [35:0] w;
      bus.window_in    = '0;
      bus.window_valid = 1'b0;
      bus.coef_we      = 1'b0;
      bus.coef_addr    = '0;
      bus.coef_data    = '0;
      reset = 1'b1;
      @(negedge clk);
      @(negedge clk);
      check_idle_outputs("reset");
      reset = 1'b0;

      // Box kernel: 8s give 72>>3=9, 15s give 135>>3=16 saturated to 15.
      win(flat(8), 9);
      idle(4);
      win(flat(15), 15);
      win(flat(8), 9);
      drain();

      // k4=-8: flat 5s cancel; lone centre 15 gives -120.
      wr(4, -8);
      win(flat(5), 0);
      w = '0;
      w[19:16] = 4'd15;
`ifdef CONV_ABS_EN
      win(w, 15);
`else
      win(w, 0);
`endif
      // 8s with centre -8: 64-64=0
      win(flat(8), 0);
      wr(4, 1);
      drain();

      // Out-of-range address ignored; same-cycle write uses the old kernel.
      wr(12, 7);
      win(flat(8), 9);
      step(1'b1, flat(8), 9, 1'b1, 0, 0);
      win(flat(8), 8);
      wr(0, 1);
      win(flat(8), 9);
      drain();

      // Framing: start from a clean position, 8 windows with random bubbles.
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      oi = 0;
      for (int i = 0; i < 8; i++) begin
         win(flat(vals[i]), outs[i]);
         idle($urandom_range(0, 2));
      end
      drain();
      for (int i = 0; i < 4; i++) win(flat(vals[7-i]), outs[7-i]);
      drain();

      // Reset with three windows in flight; none may come out.
      win(flat(15), 15);
      win(flat(15), 15);
      bus.window_in    = flat(15);
      bus.window_valid = 1'b1;
      reset = 1'b1;
      sb.delete();
      @(negedge clk);
      bus.window_valid = 1'b0;
      reset = 1'b0;
      check_idle_outputs("after_reset");
      oi = 0;
      win(flat(8), 9);
      drain();
      for (int i = 0; i < 4; i++) win(flat(vals[i]), outs[i]);
      idle(5);
      drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, bad=%0d", bad);
      $fatal(1);
   end
endmodule
